// File: rtl/ntr_resp_ctrl.sv
// ntr_resp_ctrl: card-side response controller for the NTR host bus.
// Latches a received command, then fetches response bytes one at a time
// from a byte source and presents each on ntr_dout across one host clock
// low/high period, until the opcode's byte count is exhausted.
module ntr_resp_ctrl #(
    parameter int LEN_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ntr_cs1,
    input  logic        ntr_clk,
    input  logic        cmd_ready,
    input  logic [63:0] command,
    output logic        byte_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [7:0]  ntr_dout,
    output logic        ntr_oe,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_op,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        FETCH,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       hold_data;
    logic             ntr_clk_q;
    logic             cmd_low_seen;
    logic             clk_fall;
    logic             last_byte;

    // Response length in bytes for each opcode; unknown opcodes send nothing.
    function automatic logic [LEN_W-1:0] op_len(input logic [7:0] op);
        case (op)
            8'h9F:        op_len = LEN_W'(32'h2000);
            8'h00, 8'hB7: op_len = LEN_W'(32'h200);
            8'h90, 8'hB8: op_len = LEN_W'(32'd4);
            default:      op_len = '0;
        endcase
    endfunction

    assign clk_fall   = ntr_clk_q & ~ntr_clk;
    assign last_byte  = (remaining == LEN_W'(1)) || (remaining == '0);
    assign busy       = (state != IDLE);
    assign cmd_strobe = (state == DECODE);

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; card deselect overrides every other transition.
    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (ntr_cs1) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (cmd_ready && cmd_low_seen) state_next = DECODE;
                DECODE:    state_next = (remaining == '0) ? DONE : FETCH;
                FETCH:     if (byte_valid) state_next = WAIT_LOW;
                WAIT_LOW:  if (!ntr_clk) state_next = WAIT_HIGH;
                WAIT_HIGH: if (ntr_clk) state_next = last_byte ? DONE : FETCH;
                DONE:      state_next = DONE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Command latch, byte counter, request pulse, bus data and enable.
    // NOTE: hold_data is a single byte register rather than a memory, so it
    // is reset with the rest of the datapath and never holds an unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_op    <= 8'h00;
            remaining <= '0;
            hold_data <= 8'hFF;
            ntr_dout  <= 8'hFF;
            ntr_oe    <= 1'b0;
            byte_req  <= 1'b0;
        end else begin
            // One pulse per FETCH entry, never while already waiting in FETCH.
            byte_req <= (state_next == FETCH) && (state != FETCH);
            if (ntr_cs1) begin
                remaining <= '0;
                ntr_oe    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (state_next == DECODE) begin
                            cmd_op    <= command[63:56];
                            remaining <= op_len(command[63:56]);
                        end
                    end
                    FETCH: begin
                        if (byte_valid) hold_data <= byte_data;
                    end
                    WAIT_LOW: begin
                        if (!ntr_clk) begin
                            ntr_dout <= hold_data;
                            ntr_oe   <= 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (ntr_clk && (remaining != '0)) remaining <= remaining - LEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Host clock history and sticky underrun: a falling host clock while
    // still fetching means the host sampled a byte that was not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ntr_clk_q <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            ntr_clk_q <= ntr_clk;
            if (state == DECODE) begin
                underrun <= 1'b0;
            end else if ((state == FETCH) && clk_fall) begin
                underrun <= 1'b1;
            end
        end
    end

    // Re-arm guard: a level-high cmd_ready must drop once in IDLE before
    // the same command can start another transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_low_seen <= 1'b0;
        end else if (state != IDLE) begin
            cmd_low_seen <= 1'b0;
        end else if (!cmd_ready) begin
            cmd_low_seen <= 1'b1;
        end
    end

endmodule

// File: doc/ntr_resp_ctrl.md
NTR_RESP_CTRL -- requirements
Module: ntr_resp_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 14, the width of the response byte counter.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port ntr_cs1, input, 1, card select, active low; already synchronous to clk.
REQ-005 SHALL have port ntr_clk, input, 1, host bus clock level, already synchronous to clk.
REQ-006 SHALL have port cmd_ready, input, 1, level from the parallel command receiver; high = 8 command bytes captured.
REQ-007 SHALL have port command, input, 64, the captured command; command[63:56] is the opcode.
REQ-008 SHALL have port byte_req, output, 1, one-cycle pulse requesting the next response byte.
REQ-009 SHALL have port byte_valid, input, 1, which qualifies byte_data for exactly one cycle.
REQ-010 SHALL have port byte_data, input, 8, the response byte from the source.
REQ-011 SHALL have port ntr_dout, output, 8, the data driven to the host bus.
REQ-012 SHALL have port ntr_oe, output, 1, bus output enable for ntr_dout.
REQ-013 SHALL have port cmd_strobe, output, 1, one-cycle pulse when a command is latched.
REQ-014 SHALL have port cmd_op, output, 8, the latched opcode, held until the next latch.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port underrun, output, 1, a sticky flag for a missed host clock.

Function
REQ-017 SHALL implement states IDLE, DECODE, FETCH, WAIT_LOW, WAIT_HIGH and DONE.
REQ-018 SHALL move IDLE->DECODE when cmd_ready=1 and ntr_cs1=0, and SHALL otherwise stay in IDLE.
REQ-019 SHALL, in DECODE (one cycle), latch cmd_op, pulse cmd_strobe and load remaining from the opcode table.
REQ-020 Opcode table: 0x9F->0x2000, 0x00->0x200, 0xB7->0x200, 0x90->4, 0xB8->4, any other->0.
REQ-021 SHALL move DECODE->DONE when remaining=0, and SHALL otherwise move DECODE->FETCH.
REQ-022 SHALL pulse byte_req in the first cycle of each FETCH entry only and SHALL never re-pulse while waiting.
REQ-023 SHALL, on byte_valid in FETCH, capture byte_data into a holding register and move to WAIT_LOW.
REQ-024 SHALL move WAIT_LOW->WAIT_HIGH when ntr_clk=0, updating ntr_dout from the holding register in that cycle.
REQ-025 SHALL, when ntr_clk=1 in WAIT_HIGH, decrement remaining and move to DONE if the result is 0, else to FETCH.
REQ-026 SHALL hold ntr_dout stable from the WAIT_LOW exit until the next WAIT_LOW exit.
REQ-027 SHALL drive ntr_oe=1 from the first WAIT_LOW exit until leaving DONE, and 0 otherwise.
REQ-028 SHALL hold DONE until ntr_cs1=1.
REQ-029 SHALL keep a 1-cycle registered copy of ntr_clk for edge detection.
REQ-030 SHALL set underrun on any 1->0 ntr_clk edge seen while in FETCH; the state stays FETCH.
REQ-031 SHALL clear underrun only on rst or in DECODE.
REQ-032 SHALL ignore byte_valid outside FETCH.
REQ-033 SHALL, on ntr_cs1=1 in any state, go to IDLE at the next edge, clear ntr_oe, zero remaining and not pulse byte_req.
REQ-034 SHALL give ntr_cs1=1 priority over every other transition in the same cycle, including byte_valid.
REQ-035 SHALL not re-trigger from IDLE until cmd_ready has been observed low at least once after IDLE entry.
REQ-036 SHALL size remaining at LEN_W bits, which holds 0x2000 at the default, and SHALL never wrap below 0.

Reset
REQ-037 SHALL, on rst, go to IDLE with ntr_dout=0xFF, ntr_oe=0, byte_req=0, cmd_strobe=0, cmd_op=0x00, busy=0, underrun=0 and remaining=0, asynchronously.
REQ-038 SHALL allow rst mid-transfer to abort immediately, with no further byte_req after rst asserts.

Verification
REQ-039 SHALL be verified with: opcode 0x90, source answers byte_valid 1 cycle after byte_req with 0xC2,0x0F,0x00,0x00 -> exactly 4 byte_req, 4 ntr_clk periods, ntr_dout sequence C2,0F,00,00, then DONE, ntr_oe=1.
REQ-040 SHALL be verified with: opcode 0x3C -> cmd_strobe for 1 cycle, cmd_op=0x3C, direct move to DONE, zero byte_req, ntr_oe=0.
REQ-041 SHALL be verified with: opcode 0x00 with ntr_cs1 raised after 100 bytes -> IDLE next cycle, ntr_oe=0, busy=0, no further byte_req.
REQ-042 SHALL be verified with: opcode 0xB8, byte_valid delayed past one ntr_clk falling edge -> underrun=1, transfer still completes 4 bytes, underrun clears on the next DECODE.
REQ-043 SHALL be verified with: opcode 0x9F -> 0x2000 bytes served and remaining reaches 0 without wrap, DONE held until cs1 high.
REQ-044 SHALL be verified with: rst pulsed while in WAIT_HIGH -> all outputs at reset values in the same cycle, with cmd_ready held high causing no retrigger until it drops.
